// File: rtl/result_collector.sv
// result_collector: drain end of the systolic array.
// Captures skewed per-column result beats, deskews them into a row-major
// result memory, flags completion of a full N x N matrix and offers a
// registered read port to the host.
module result_collector #(
   parameter int MATRIX_SIZE = 2,
   parameter int DATA_SIZE   = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           clear,
   input  logic [MATRIX_SIZE-1:0]         col_valid,
   input  logic [DATA_SIZE-1:0]           col_data [MATRIX_SIZE-1:0],
   input  logic                           rd_en,
   input  logic [$clog2(MATRIX_SIZE*MATRIX_SIZE):0] rd_addr,
   output logic [DATA_SIZE-1:0]           rd_data,
   output logic                           rd_valid,
   output logic                           busy,
   output logic                           done,
   output logic                           overflow
);

   localparam int DEPTH = MATRIX_SIZE * MATRIX_SIZE;
   localparam int CW    = $clog2(MATRIX_SIZE + 1);
   localparam int AW    = $clog2(DEPTH) + 1;
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [CW-1:0]          cnt      [MATRIX_SIZE];
   logic [CW-1:0]          cnt_next [MATRIX_SIZE];
   logic [IW-1:0]          wr_addr  [MATRIX_SIZE];
   logic [MATRIX_SIZE-1:0] accept;
   logic [MATRIX_SIZE-1:0] ovf_hit;
   logic                   all_full;
   logic [DATA_SIZE-1:0]   rmem     [DEPTH];

   // Per-column accept/overflow decisions and the next state; completion is
   // judged on the post-write counter values so DONE lands with the last beat.
   always_comb begin
      accept     = '0;
      ovf_hit    = '0;
      all_full   = 1'b1;
      state_next = state;
      for (int c = 0; c < MATRIX_SIZE; c++) begin
         cnt_next[c] = cnt[c];
         wr_addr[c]  = IW'(int'(cnt[c]) * MATRIX_SIZE + c);
         if (enable && !clear && col_valid[c]) begin
            if (state != DONE && cnt[c] < CW'(MATRIX_SIZE)) begin
               accept[c]   = 1'b1;
               cnt_next[c] = cnt[c] + CW'(1);
            end else begin
               ovf_hit[c] = 1'b1;
            end
         end
         if (cnt_next[c] != CW'(MATRIX_SIZE)) begin
            all_full = 1'b0;
         end
      end
      if (clear) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (|accept) state_next = all_full ? DONE : COLLECT;
            COLLECT: if (all_full) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Column row counters; clear rewinds every column for a new matrix.
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         for (int c = 0; c < MATRIX_SIZE; c++) cnt[c] <= '0;
      end else begin
         for (int c = 0; c < MATRIX_SIZE; c++) cnt[c] <= cnt_next[c];
      end
   end

   // Result memory: each accepted beat lands at row cnt[c], column c.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) rmem[i] <= '0;
      end else begin
         for (int c = 0; c < MATRIX_SIZE; c++) begin
            if (accept[c]) rmem[wr_addr[c]] <= col_data[c];
         end
      end
   end

   // Sticky overflow flag, cleared only by reset or clear.
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         overflow <= 1'b0;
      end else if (|ovf_hit) begin
         overflow <= 1'b1;
      end
   end

   // Registered read port; sees the memory before this cycle's writes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            if (rd_addr < AW'(DEPTH)) rd_data <= rmem[rd_addr[IW-1:0]];
            else                      rd_data <= '0;
         end
      end
   end

   assign busy = (state == COLLECT);
   assign done = (state == DONE);

endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: directed and randomized checks of result_collector
// against a matrix-level reference model.
module tb_result_collector;

   localparam int N  = 2;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          clear;
   logic [N-1:0]  col_valid;
   logic [DW-1:0] col_data [N-1:0];
   logic          rd_en;
   logic [2:0]    rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          busy;
   logic          done;
   logic          overflow;

   // Reference model: matrix contents, rows filled per column, phase.
   logic [DW-1:0] m_mat [N*N];
   int            m_rows [N];
   int            m_phase;
   logic          m_ovf;
   logic [DW-1:0] m_rd_data;
   logic          m_rd_valid;

   int num_checks = 0;
   int num_fail   = 0;

   result_collector #(.MATRIX_SIZE(N), .DATA_SIZE(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .clear     (clear),
      .col_valid (col_valid),
      .col_data  (col_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_fail++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic modelStep();
      bit any_new;
      bit full;
      if (!reset) begin
         foreach (m_mat[i]) m_mat[i] = '0;
         foreach (m_rows[c]) m_rows[c] = 0;
         m_phase    = 0;
         m_ovf      = 1'b0;
         m_rd_data  = '0;
         m_rd_valid = 1'b0;
         return;
      end
      m_rd_valid = rd_en;
      if (rd_en) m_rd_data = (int'(rd_addr) < N*N) ? m_mat[int'(rd_addr)] : '0;
      if (clear) begin
         foreach (m_rows[c]) m_rows[c] = 0;
         m_phase = 0;
         m_ovf   = 1'b0;
      end else if (enable) begin
         any_new = 0;
         for (int c = 0; c < N; c++) begin
            if (col_valid[c]) begin
               if (m_phase == 2 || m_rows[c] == N) begin
                  m_ovf = 1'b1;
               end else begin
                  m_mat[m_rows[c] * N + c] = col_data[c];
                  m_rows[c]++;
                  any_new = 1;
               end
            end
         end
         full = 1;
         foreach (m_rows[c]) if (m_rows[c] != N) full = 0;
         if (any_new) m_phase = full ? 2 : 1;
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic en, input logic clr,
                                input logic [1:0] v, input logic [31:0] d1, input logic [31:0] d0,
                                input logic re, input logic [2:0] ra);
      reset     = rst;
      enable    = en;
      clear     = clr;
      col_valid = v;
      col_data[1] = d1;
      col_data[0] = d0;
      rd_en     = re;
      rd_addr   = ra;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("busy",     32'(busy),     32'(m_phase == 1));
      checkOutput("done",     32'(done),     32'(m_phase == 2));
      checkOutput("overflow", 32'(overflow), 32'(m_ovf));
      checkOutput("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      checkOutput("rd_data",  rd_data,       m_rd_data);
   endtask

   task automatic idleRead(input logic [2:0] ra);
      applyStimulus(1, 1, 0, 2'b00, 0, 0, 1, ra);
   endtask

   initial begin
      foreach (m_mat[i]) m_mat[i] = '0;
      foreach (m_rows[c]) m_rows[c] = 0;
      m_phase = 0; m_ovf = 0; m_rd_data = '0; m_rd_valid = 0;
      #2;
      applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0);

      $display("[TB] skewed fill");
      applyStimulus(1, 1, 0, 2'b01, 32'hdead, 7, 0, 0);
      checkOutput("t1_busy", 32'(busy), 1);
      applyStimulus(1, 1, 0, 2'b11, 5, 8, 0, 0);
      applyStimulus(1, 1, 0, 2'b10, 6, 32'hbeef, 0, 0);
      checkOutput("t1_done", 32'(done), 1);
      for (int a = 0; a < 4; a++) idleRead(3'(a));
      applyStimulus(1, 1, 0, 2'b00, 0, 0, 0, 0);
      checkOutput("t1_last", rd_data, 6);

      $display("[TB] overflow while done, then clear");
      applyStimulus(1, 1, 0, 2'b01, 0, 9, 0, 0);
      checkOutput("t2_ovf", 32'(overflow), 1);
      idleRead(0);
      checkOutput("t2_addr0", rd_data, 7);
      applyStimulus(1, 1, 1, 2'b00, 0, 0, 1, 0);
      checkOutput("t2_clr", 32'(done), 0);

      $display("[TB] hold with enable low");
      applyStimulus(1, 1, 0, 2'b01, 0, 32'h11, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 2'b11, 32'h99, 32'h98, 0, 0);
      applyStimulus(1, 1, 0, 2'b11, 32'h21, 32'h12, 0, 0);
      applyStimulus(1, 1, 0, 2'b10, 32'h22, 0, 0, 0);
      for (int a = 0; a < 4; a++) idleRead(3'(a));

      $display("[TB] clear with simultaneous beats");
      applyStimulus(1, 1, 1, 2'b11, 32'h55, 32'h44, 0, 0);
      checkOutput("t4_idle", 32'(busy | done), 0);
      applyStimulus(1, 1, 0, 2'b11, 32'h77, 32'h66, 1, 0);

      $display("[TB] reset mid-collect");
      applyStimulus(0, 1, 0, 2'b00, 0, 0, 0, 0);
      for (int a = 0; a < 4; a++) idleRead(3'(a));

      $display("[TB] out-of-range and read-before-write");
      idleRead(3'd4);
      applyStimulus(1, 1, 0, 2'b01, 0, 32'h10, 0, 0);
      idleRead(3'd1);
      applyStimulus(1, 1, 0, 2'b11, 32'hab, 32'h20, 1, 3'd1);
      checkOutput("t6_old", rd_data, 0);
      idleRead(3'd1);
      checkOutput("t6_new", rd_data, 32'hab);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                       ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
                       2'($urandom_range(0, 3)), $urandom, $urandom,
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule
